// File: rtl/ds_pkg.sv
// ds_pkg: constants and types shared by the downsampling address generator.
//   PTR_W      : width of every row/column pointer driven towards the MAR
//   MAR_*      : MAR select codes (hold, accumulator, read, write)
//   ds_state_e : sequencing FSM state encoding
package ds_pkg;

   localparam int unsigned PTR_W = 8;

   localparam logic [1:0] MAR_HOLD  = 2'b00;
   localparam logic [1:0] MAR_AC    = 2'b01;
   localparam logic [1:0] MAR_READ  = 2'b10;
   localparam logic [1:0] MAR_WRITE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      FIN   = 2'b11
   } ds_state_e;

endpackage

// File: rtl/ds_wrap_counter.sv
// ds_wrap_counter: up-counter over 0..LIMIT-1 that wraps back to 0.
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset, count -> 0
//   clear  : synchronous clear, count -> 0
//   enable : advance one step (wrapping at LIMIT-1)
//   count  : current value
//   wrap   : high while count sits at LIMIT-1 (next enable wraps)
module ds_wrap_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   assign wrap = (count == LAST);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ds_addr_gen.sv
// ds_addr_gen: walks every output pixel of a 2:1 row/column downsample and
// presents read and write pointers to the MAR under a valid/ready handshake.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : begin a full-frame sweep (sampled only in IDLE)
//   addr_ready   : consumer accepted the current address this cycle
//   addr_valid   : pointers and MAR_control are valid
//   MAR_control  : 2'b10 read, 2'b11 write, 2'b00 hold
//   RRR/CRR_out  : read row/column pointer
//   RWR/CWR_out  : write row/column pointer
//   busy         : sweep in progress
//   done         : one-cycle pulse after the last write address is accepted
// Build option DS_AVERAGE_EN: when defined, four reads (2x2 window) per output
// pixel; when undefined, a single read at (2ow,2oc) (pure decimation).
module ds_addr_gen
   import ds_pkg::*;
#(
   parameter int unsigned IN_ROWS = 256,
   parameter int unsigned IN_COLS = 128
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             addr_ready,
   output logic             addr_valid,
   output logic [1:0]       MAR_control,
   output logic [PTR_W-1:0] RRR_out,
   output logic [PTR_W-1:0] CRR_out,
   output logic [PTR_W-1:0] RWR_out,
   output logic [PTR_W-1:0] CWR_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned OUT_ROWS = IN_ROWS / 2;
   localparam int unsigned OUT_COLS = IN_COLS / 2;
   // ow <= 127 and oc <= 63 for legal sizes, so read pointers are exactly
   // {ow, row-bit} and {0, oc, col-bit} with no adder.
   localparam int unsigned ROW_W = PTR_W - 1;
   localparam int unsigned COL_W = PTR_W - 2;

   ds_state_e state_q, state_d;

   logic [ROW_W-1:0] ow;
   logic [COL_W-1:0] oc;
   logic             ow_wrap, oc_wrap;
   logic             ow_en, oc_en;
   logic             cnt_clear;

   ds_wrap_counter #(
      .WIDTH (COL_W),
      .LIMIT (OUT_COLS)
   ) u_oc (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (oc_en),
      .count  (oc),
      .wrap   (oc_wrap)
   );

   ds_wrap_counter #(
      .WIDTH (ROW_W),
      .LIMIT (OUT_ROWS)
   ) u_ow (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (ow_en),
      .count  (ow),
      .wrap   (ow_wrap)
   );

`ifdef DS_AVERAGE_EN
   logic [1:0] k;
   logic       k_wrap;
   logic       k_en;

   ds_wrap_counter #(
      .WIDTH (2),
      .LIMIT (4)
   ) u_k (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (k_en),
      .count  (k),
      .wrap   (k_wrap)
   );

   // k[1] selects the odd input row, k[0] the odd input column.
   assign RRR_out = {ow, k[1]};
   assign CRR_out = {1'b0, oc, k[0]};
`else
   assign RRR_out = {ow, 1'b0};
   assign CRR_out = {1'b0, oc, 1'b0};
`endif

   assign RWR_out = {1'b0, ow};
   assign CWR_out = {2'b00, oc};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and counter controls. addr_valid is high in READ and WRITE,
   // so addr_ready alone qualifies a fire there.
   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      oc_en     = 1'b0;
      ow_en     = 1'b0;
`ifdef DS_AVERAGE_EN
      k_en      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_clear = 1'b1;
               state_d   = READ;
            end
         end
         READ: begin
            if (addr_ready) begin
`ifdef DS_AVERAGE_EN
               k_en = 1'b1;
               if (k_wrap) begin
                  state_d = WRITE;
               end
`else
               state_d = WRITE;
`endif
            end
         end
         WRITE: begin
            if (addr_ready) begin
               oc_en = 1'b1;
               ow_en = oc_wrap;
               // Both counters wrap on the last pixel, leaving them at 0.
               state_d = (oc_wrap && ow_wrap) ? FIN : READ;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control outputs decode straight from the state register.
   always_comb begin
      addr_valid  = 1'b0;
      MAR_control = MAR_HOLD;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         READ: begin
            addr_valid  = 1'b1;
            MAR_control = MAR_READ;
            busy        = 1'b1;
         end
         WRITE: begin
            addr_valid  = 1'b1;
            MAR_control = MAR_WRITE;
            busy        = 1'b1;
         end
         FIN: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ds_addr_gen.sv
// tb_ds_addr_gen: directed, table-driven bench for ds_addr_gen. A 4x4
// instance covers sequencing, stalls, reset and restart; a default-size
// instance covers the full 256x128 frame.
module tb_ds_addr_gen;

   localparam logic [1:0] RD   = 2'b10;
   localparam logic [1:0] WR   = 2'b11;
   localparam logic [1:0] HOLD = 2'b00;

`ifdef DS_AVERAGE_EN
   localparam int MAIN_N   = 20;
   localparam int STALL_N  = 8;
   localparam int FULL_RDS = 32768;
   localparam int LAST_RRR = 255;
   localparam int LAST_CRR = 127;
`else
   localparam int MAIN_N   = 8;
   localparam int STALL_N  = 6;
   localparam int FULL_RDS = 8192;
   localparam int LAST_RRR = 254;
   localparam int LAST_CRR = 126;
`endif

   typedef struct {
      logic       ready;
      logic [1:0] mar;
      logic [7:0] row;
      logic [7:0] col;
   } vec_t;

   logic       clock;
   logic       reset;
   logic       start;
   logic       addr_ready;
   logic       addr_valid;
   logic [1:0] MAR_control;
   logic [7:0] RRR_out, CRR_out, RWR_out, CWR_out;
   logic       busy, done;

   logic       start_f;
   logic       ready_f;
   logic       addr_valid_f;
   logic [1:0] MAR_control_f;
   logic [7:0] RRR_f, CRR_f, RWR_f, CWR_f;
   logic       busy_f, done_f;

   vec_t main_tab [MAIN_N];
   vec_t stall_tab [STALL_N];

   int n_asserts = 0;
   int n_fail    = 0;

   ds_addr_gen #(
      .IN_ROWS (4),
      .IN_COLS (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .addr_ready  (addr_ready),
      .addr_valid  (addr_valid),
      .MAR_control (MAR_control),
      .RRR_out     (RRR_out),
      .CRR_out     (CRR_out),
      .RWR_out     (RWR_out),
      .CWR_out     (CWR_out),
      .busy        (busy),
      .done        (done)
   );

   ds_addr_gen dut_full (
      .clock       (clock),
      .reset       (reset),
      .start       (start_f),
      .addr_ready  (ready_f),
      .addr_valid  (addr_valid_f),
      .MAR_control (MAR_control_f),
      .RRR_out     (RRR_f),
      .CRR_out     (CRR_f),
      .RWR_out     (RWR_f),
      .CWR_out     (CWR_f),
      .busy        (busy_f),
      .done        (done_f)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic r, input logic [1:0] m, input int rw, input int cl);
      vec_t v;
      v.ready = r;
      v.mar   = m;
      v.row   = 8'(rw);
      v.col   = 8'(cl);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input vec_t v);
      chk({tag, ".valid"}, 32'(addr_valid), 32'd1);
      chk({tag, ".mar"}, 32'(MAR_control), 32'(v.mar));
      if (v.mar == RD) begin
         chk({tag, ".RRR"}, 32'(RRR_out), 32'(v.row));
         chk({tag, ".CRR"}, 32'(CRR_out), 32'(v.col));
      end else begin
         chk({tag, ".RWR"}, 32'(RWR_out), 32'(v.row));
         chk({tag, ".CWR"}, 32'(CWR_out), 32'(v.col));
      end
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
   endtask

   task automatic chk_ctl(input string tag, input logic exp_done);
      chk({tag, ".valid"}, 32'(addr_valid), 32'd0);
      chk({tag, ".mar"}, 32'(MAR_control), 32'(HOLD));
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".done"}, 32'(done), 32'(exp_done));
   endtask

   task automatic chk_zero(input string tag);
      chk_ctl(tag, 1'b0);
      chk({tag, ".RRR"}, 32'(RRR_out), 32'd0);
      chk({tag, ".CRR"}, 32'(CRR_out), 32'd0);
      chk({tag, ".RWR"}, 32'(RWR_out), 32'd0);
      chk({tag, ".CWR"}, 32'(CWR_out), 32'd0);
   endtask

   // Entered at the falling edge where the first table entry is visible;
   // returns at the falling edge after the last entry.
   task automatic run_table(input string tag, input int n, input logic hold, input bit use_stall);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v          = use_stall ? stall_tab[i] : main_tab[i];
         start      = hold;
         addr_ready = v.ready;
         chk_vec($sformatf("%s[%0d]", tag, i), v);
         @(negedge clock);
      end
   endtask

   initial begin
      bit found;
      bit bit7_seen;
      bit timed_out;
      int writes, reads;
      logic [7:0] last_rrr, last_crr, last_rwr, last_cwr;

      reset      = 1'b1;
      start      = 1'b0;
      addr_ready = 1'b0;
      start_f    = 1'b0;
      ready_f    = 1'b1;

`ifdef DS_AVERAGE_EN
      main_tab[0]  = mk(1, RD, 0, 0);
      main_tab[1]  = mk(1, RD, 0, 1);
      main_tab[2]  = mk(1, RD, 1, 0);
      main_tab[3]  = mk(1, RD, 1, 1);
      main_tab[4]  = mk(1, WR, 0, 0);
      main_tab[5]  = mk(1, RD, 0, 2);
      main_tab[6]  = mk(1, RD, 0, 3);
      main_tab[7]  = mk(1, RD, 1, 2);
      main_tab[8]  = mk(1, RD, 1, 3);
      main_tab[9]  = mk(1, WR, 0, 1);
      main_tab[10] = mk(1, RD, 2, 0);
      main_tab[11] = mk(1, RD, 2, 1);
      main_tab[12] = mk(1, RD, 3, 0);
      main_tab[13] = mk(1, RD, 3, 1);
      main_tab[14] = mk(1, WR, 1, 0);
      main_tab[15] = mk(1, RD, 2, 2);
      main_tab[16] = mk(1, RD, 2, 3);
      main_tab[17] = mk(1, RD, 3, 2);
      main_tab[18] = mk(1, RD, 3, 3);
      main_tab[19] = mk(1, WR, 1, 1);
      stall_tab[0] = mk(1, RD, 0, 0);
      stall_tab[1] = mk(0, RD, 0, 1);
      stall_tab[2] = mk(0, RD, 0, 1);
      stall_tab[3] = mk(1, RD, 0, 1);
      stall_tab[4] = mk(1, RD, 1, 0);
      stall_tab[5] = mk(1, RD, 1, 1);
      stall_tab[6] = mk(1, WR, 0, 0);
      stall_tab[7] = mk(1, RD, 0, 2);
`else
      main_tab[0]  = mk(1, RD, 0, 0);
      main_tab[1]  = mk(1, WR, 0, 0);
      main_tab[2]  = mk(1, RD, 0, 2);
      main_tab[3]  = mk(1, WR, 0, 1);
      main_tab[4]  = mk(1, RD, 2, 0);
      main_tab[5]  = mk(1, WR, 1, 0);
      main_tab[6]  = mk(1, RD, 2, 2);
      main_tab[7]  = mk(1, WR, 1, 1);
      stall_tab[0] = mk(1, RD, 0, 0);
      stall_tab[1] = mk(0, WR, 0, 0);
      stall_tab[2] = mk(0, WR, 0, 0);
      stall_tab[3] = mk(1, WR, 0, 0);
      stall_tab[4] = mk(1, RD, 0, 2);
      stall_tab[5] = mk(1, WR, 0, 1);
`endif

      repeat (2) @(negedge clock);
      chk_zero("in_reset");
      reset = 1'b0;
      @(negedge clock);
      chk_zero("after_reset");

      // Sweep A with start held high throughout: must not restart while busy.
      start = 1'b1;
      @(negedge clock);
      run_table("sweepA", MAIN_N, 1'b1, 1'b0);
      chk_ctl("finA", 1'b1);
      @(negedge clock);
      chk_ctl("idle_between", 1'b0);
      @(negedge clock);
      // start still high in IDLE, so sweep B is already presenting its first read.
      run_table("sweepB", MAIN_N, 1'b0, 1'b0);
      chk_ctl("finB", 1'b1);
      @(negedge clock);
      chk_ctl("idleB", 1'b0);
      @(negedge clock);
      chk_ctl("idleB_stays", 1'b0);

      // Backpressure on the handshake.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      run_table("stall", STALL_N, 1'b0, 1'b1);

      // Reset while stalled mid-sweep.
      addr_ready = 1'b0;
      reset      = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk_zero("rst_stall");
      addr_ready = 1'b1;

      // Reset during WRITE of output pixel (1,0), then restart from (0,0).
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (MAR_control == WR && RWR_out == 8'd1 && CWR_out == 8'd0) begin
            found = 1'b1;
            break;
         end
         @(negedge clock);
      end
      chk("rst_write.reached", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk_zero("rst_write");
      @(negedge clock);
      chk_zero("rst_write_idle");
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk_vec("restart[0]", main_tab[0]);
      @(negedge clock);
      chk_vec("restart[1]", main_tab[1]);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;

      // Full default-size frame with addr_ready tied high.
      writes    = 0;
      reads     = 0;
      bit7_seen = 1'b0;
      timed_out = 1'b1;
      last_rrr  = '0;
      last_crr  = '0;
      last_rwr  = '0;
      last_cwr  = '0;
      start_f   = 1'b1;
      @(negedge clock);
      start_f = 1'b0;
      for (int c = 0; c < 50000; c++) begin
         if (done_f) begin
            timed_out = 1'b0;
            break;
         end
         if (CRR_f[7] || CWR_f[7]) bit7_seen = 1'b1;
         if (addr_valid_f && MAR_control_f == WR) begin
            writes++;
            last_rwr = RWR_f;
            last_cwr = CWR_f;
         end else if (addr_valid_f && MAR_control_f == RD) begin
            reads++;
            last_rrr = RRR_f;
            last_crr = CRR_f;
         end
         @(negedge clock);
      end
      chk("full.done_seen", 32'(timed_out), 32'd0);
      chk("full.writes", 32'(writes), 32'd8192);
      chk("full.reads", 32'(reads), 32'(FULL_RDS));
      chk("full.last_RWR", 32'(last_rwr), 32'd127);
      chk("full.last_CWR", 32'(last_cwr), 32'd63);
      chk("full.last_RRR", 32'(last_rrr), 32'(LAST_RRR));
      chk("full.last_CRR", 32'(last_crr), 32'(LAST_CRR));
      chk("full.bit7", 32'(bit7_seen), 32'd0);
      @(negedge clock);
      chk("full.done_pulse", 32'(done_f), 32'd0);
      chk("full.busy_after", 32'(busy_f), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
